// File: rtl/hdmi_link_sequencer.sv
// Power-up / recovery sequencer for the TMDS output path: pulses the pixel MMCM reset,
// qualifies lock, debounces hot-plug detect and gates the pixel reset and video enable.
module hdmi_link_sequencer #(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT    = 200000,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk_200mhz,
    input  logic       rst,
    input  logic       restart,
    input  logic       mmcm_locked,
    input  logic       hdmi_hpd,
    output logic       mmcm_rst,
    output logic       pixel_rst,
    output logic       video_en,
    output logic       hpd_db,
    output logic [2:0] state_o,
    output logic [7:0] lock_fail_cnt
);

    localparam logic [2:0] S_MMCM_RST  = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_WAIT_HPD  = 3'd3;
    localparam logic [2:0] S_ACTIVE    = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             locked_meta_q, locked_s_q;
    logic             hpd_meta_q, hpd_s_q;
    logic             hpd_db_q, hpd_db_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       fail_q, fail_d;
    logic             fail_inc;
    logic             mmcm_rst_q, pixel_rst_q, video_en_q;

    // HPD debounce: a new level must persist for DEBOUNCE_CYCLES synchronized samples.
    always_comb begin
        hpd_db_d = hpd_db_q;
        dcnt_d   = '0;
        if (hpd_s_q != hpd_db_q) begin
            if (dcnt_q == DB_LAST) begin
                hpd_db_d = hpd_s_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fail_inc = 1'b0;
        if (restart) begin
            state_d = S_MMCM_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_MMCM_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d  = S_MMCM_RST;
                        cnt_d    = '0;
                        fail_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!locked_s_q) begin
                        state_d  = S_MMCM_RST;
                        cnt_d    = '0;
                        fail_inc = 1'b1;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = S_WAIT_HPD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_HPD, S_ACTIVE: begin
                    if (!locked_s_q) begin
                        state_d  = S_MMCM_RST;
                        cnt_d    = '0;
                        fail_inc = 1'b1;
                    end else if (hpd_db_q != (state_q == S_ACTIVE)) begin
                        state_d = hpd_db_q ? S_ACTIVE : S_WAIT_HPD;
                    end
                end
                default: begin
                    state_d = S_MMCM_RST;
                    cnt_d   = '0;
                end
            endcase
        end
        fail_d = (fail_inc && (fail_q != 8'hFF)) ? fail_q + 8'd1 : fail_q;
    end

    // Outputs decode the next state so they change in the same cycle as state_q.
    always_ff @(posedge clk_200mhz) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            hpd_meta_q    <= 1'b0;
            hpd_s_q       <= 1'b0;
            hpd_db_q      <= 1'b0;
            dcnt_q        <= '0;
            state_q       <= S_MMCM_RST;
            cnt_q         <= '0;
            fail_q        <= 8'd0;
            mmcm_rst_q    <= 1'b1;
            pixel_rst_q   <= 1'b1;
            video_en_q    <= 1'b0;
        end else begin
            locked_meta_q <= mmcm_locked;
            locked_s_q    <= locked_meta_q;
            hpd_meta_q    <= hdmi_hpd;
            hpd_s_q       <= hpd_meta_q;
            hpd_db_q      <= hpd_db_d;
            dcnt_q        <= dcnt_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fail_q        <= fail_d;
            mmcm_rst_q    <= (state_d == S_MMCM_RST);
            pixel_rst_q   <= (state_d == S_MMCM_RST) || (state_d == S_WAIT_LOCK) ||
                             (state_d == S_SETTLE);
            video_en_q    <= (state_d == S_ACTIVE);
        end
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign pixel_rst     = pixel_rst_q;
    assign video_en      = video_en_q;
    assign hpd_db        = hpd_db_q;
    assign state_o       = state_q;
    assign lock_fail_cnt = fail_q;

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed bench for hdmi_link_sequencer: a bring-up vector table plus hand-timed
// sequences for HPD glitches, lock loss, restart, mid-run reset and lock timeout.
module tb_hdmi_link_sequencer;

    logic       clk = 1'b0;
    logic       rst, restart, mmcm_locked, hdmi_hpd;
    logic       mmcm_rst, pixel_rst, video_en, hpd_db;
    logic [2:0] state_o;
    logic [7:0] lock_fail_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    hdmi_link_sequencer #(
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (20),
        .SETTLE_CYCLES  (8),
        .DEBOUNCE_CYCLES(5),
        .CNT_W          (24)
    ) dut (
        .clk_200mhz   (clk),
        .rst          (rst),
        .restart      (restart),
        .mmcm_locked  (mmcm_locked),
        .hdmi_hpd     (hdmi_hpd),
        .mmcm_rst     (mmcm_rst),
        .pixel_rst    (pixel_rst),
        .video_en     (video_en),
        .hpd_db       (hpd_db),
        .state_o      (state_o),
        .lock_fail_cnt(lock_fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        restart;
        logic        locked;
        logic        hpd;
        int          ncyc;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[10];

    // {state, mmcm_rst, pixel_rst, video_en, hpd_db, lock_fail_cnt}
    function automatic logic [14:0] ex(input logic [2:0] s, input logic m, input logic p,
                                       input logic v, input logic h, input logic [7:0] f);
        return {s, m, p, v, h, f};
    endfunction

    function automatic logic [14:0] outs();
        return {state_o, mmcm_rst, pixel_rst, video_en, hpd_db, lock_fail_cnt};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, got);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, ex(3'd0, 1, 1, 0, 0, 8'd0)};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, ex(3'd0, 1, 1, 0, 0, 8'd0)};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, ex(3'd1, 0, 1, 0, 0, 8'd0)};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, ex(3'd1, 0, 1, 0, 0, 8'd0)};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, ex(3'd1, 0, 1, 0, 1, 8'd0)};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, ex(3'd2, 0, 1, 0, 1, 8'd0)};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 7, ex(3'd2, 0, 1, 0, 1, 8'd0)};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, ex(3'd3, 0, 0, 0, 1, 8'd0)};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, ex(3'd4, 0, 0, 1, 1, 8'd0)};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 5, ex(3'd4, 0, 0, 1, 1, 8'd0)};

        rst = 1'b1; restart = 1'b0; mmcm_locked = 1'b0; hdmi_hpd = 1'b1;

        // Nominal bring-up
        for (int i = 0; i < 10; i++) begin
            rst         = vecs[i].rst;
            restart     = vecs[i].restart;
            mmcm_locked = vecs[i].locked;
            hdmi_hpd    = vecs[i].hpd;
            step(vecs[i].ncyc);
            chk($sformatf("bringup[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // HPD glitch of 3 cycles is filtered
        hdmi_hpd = 1'b0; step(3);
        hdmi_hpd = 1'b1; step(10);
        chk("glitch_outs", 32'(outs()), 32'(ex(3'd4, 0, 0, 1, 1, 8'd0)));

        // HPD low 10 cycles: hpd_db falls 7 cycles after the pin, then WAIT_HPD
        hdmi_hpd = 1'b0; step(6);
        chk("unplug_db_t6", 32'(hpd_db), 32'd1);
        step(1);
        chk("unplug_db_t7", 32'(hpd_db), 32'd0);
        chk("unplug_state_t7", 32'(state_o), 32'd4);
        step(1);
        chk("unplug_outs_t8", 32'(outs()), 32'(ex(3'd3, 0, 0, 0, 0, 8'd0)));
        step(2);
        hdmi_hpd = 1'b1; step(8);
        chk("replug_outs", 32'(outs()), 32'(ex(3'd4, 0, 0, 1, 1, 8'd0)));

        // One-cycle lock drop in ACTIVE
        mmcm_locked = 1'b0; step(1);
        mmcm_locked = 1'b1; step(1);
        chk("lockloss_t2", 32'(state_o), 32'd4);
        step(1);
        chk("lockloss_t3", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 1, 8'd1)));
        step(4);
        chk("lockloss_waitlock", 32'(outs()), 32'(ex(3'd1, 0, 1, 0, 1, 8'd1)));
        step(10);
        chk("lockloss_recover", 32'(outs()), 32'(ex(3'd4, 0, 0, 1, 1, 8'd1)));

        // Restart in ACTIVE, then again in SETTLE
        restart = 1'b1; step(1);
        restart = 1'b0;
        chk("restart_active", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 1, 8'd1)));
        step(3);
        chk("restart_pulse_end", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 1, 8'd1)));
        step(1);
        chk("restart_waitlock", 32'(outs()), 32'(ex(3'd1, 0, 1, 0, 1, 8'd1)));
        step(1);
        chk("restart_settle", 32'(state_o), 32'd2);
        step(2);
        restart = 1'b1; step(1);
        restart = 1'b0;
        chk("restart_in_settle", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 1, 8'd1)));
        step(3);
        chk("restart2_pulse_end", 32'(mmcm_rst), 32'd1);
        step(1);
        chk("restart2_waitlock", 32'(state_o), 32'd1);
        step(10);
        chk("restart2_recover", 32'(outs()), 32'(ex(3'd4, 0, 0, 1, 1, 8'd1)));

        // Mid-operation reset
        rst = 1'b1; mmcm_locked = 1'b0; step(1);
        chk("midrun_rst", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 0, 8'd0)));
        step(1);
        rst = 1'b0;

        // Lock never arrives: retry every 24 cycles, counter saturates at 255
        step(23);
        chk("timeout_before", 32'({state_o, lock_fail_cnt}), 32'({3'd1, 8'd0}));
        step(1);
        chk("timeout_1", 32'({state_o, mmcm_rst, lock_fail_cnt}), 32'({3'd0, 1'b1, 8'd1}));
        step(4);
        chk("timeout_retry_wait", 32'({state_o, mmcm_rst}), 32'({3'd1, 1'b0}));
        step(20);
        chk("timeout_2", 32'({state_o, lock_fail_cnt}), 32'({3'd0, 8'd2}));
        step(24 * 252);
        chk("timeout_254", 32'(lock_fail_cnt), 32'd254);
        step(24);
        chk("timeout_255", 32'(lock_fail_cnt), 32'd255);
        step(24);
        chk("timeout_saturated", 32'({state_o, mmcm_rst, lock_fail_cnt}),
            32'({3'd0, 1'b1, 8'd255}));

        rst = 1'b1; step(1);
        chk("rst_clears_fail", 32'(outs()), 32'(ex(3'd0, 1, 1, 0, 0, 8'd0)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
